// File: rtl/sync_d_pkg.sv
// Shared width helpers for the sync_d delay pipeline.
package sync_d_pkg;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int tap_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/sync_d_stage.sv
// One pipeline stage: data word plus valid flag.
// Priority: reset, then flush, then shift, otherwise hold.
module sync_d_stage #(
    parameter int              WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             en,
    input  logic [WIDTH-1:0] data_i,
    input  logic             valid_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (clear) begin
            data_d  = RESET_VAL;
            valid_d = 1'b0;
        end else if (en) begin
            data_d  = data_i;
            valid_d = valid_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            data_q  <= RESET_VAL;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/sync_d_pipe.sv
// WIDTH x DEPTH register delay line with per-stage valids, stall, flush,
// occupancy count and a selectable tap onto any stage.
module sync_d_pipe
    import sync_d_pkg::*;
#(
    parameter  int               WIDTH     = 8,
    parameter  int               DEPTH     = 4,
    parameter  logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int               TAP_W     = tap_w(DEPTH),
    localparam int               CNT_W     = cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clear,
    input  logic [WIDTH-1:0] data,
    input  logic             data_valid,
    input  logic [TAP_W-1:0] tap_sel,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    output logic [WIDTH-1:0] tap,
    output logic             tap_valid,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] data_q [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [CNT_W-1:0] count_q, count_d;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic [WIDTH-1:0] d_in;
        logic             v_in;
        if (i == 0) begin : g_first
            assign d_in = data;
            assign v_in = data_valid;
        end else begin : g_next
            assign d_in = data_q[i-1];
            assign v_in = valid_q[i-1];
        end
        sync_d_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk     (clk),
            .reset   (reset),
            .clear   (clear),
            .en      (en),
            .data_i  (d_in),
            .valid_i (v_in),
            .data_o  (data_q[i]),
            .valid_o (valid_q[i])
        );
    end

    // Occupancy tracks beats entering stage 0 minus beats leaving the last stage.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (en) begin
            if (data_valid && !valid_q[DEPTH-1]) begin
                count_d = count_q + CNT_W'(1);
            end else if (!data_valid && valid_q[DEPTH-1]) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    if (DEPTH == 1) begin : g_tap_single
        logic unused_tap_sel;
        assign unused_tap_sel = ^tap_sel;
        assign tap            = data_q[0];
        assign tap_valid      = valid_q[0];
    end else begin : g_tap_mux
        // Out-of-range selects (non-power-of-two DEPTH) fall through to the reset value.
        always_comb begin
            tap       = RESET_VAL;
            tap_valid = 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                if (int'(tap_sel) == i) begin
                    tap       = data_q[i];
                    tap_valid = valid_q[i];
                end
            end
        end
    end

    assign result       = data_q[DEPTH-1];
    assign result_valid = valid_q[DEPTH-1];
    assign count        = count_q;

endmodule
